// File: rtl/stream_demux2.sv
// stream_demux2: 1-to-2 valid/ready demultiplexer.
// Each output owns a FIFO so one stalled sink never blocks the other.

// Per-output FIFO; full/empty come from the count, never from pointers.
module stream_demux2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (count == CW'(DEPTH));
  assign valid_o = (count != '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = valid_o && ready_i;
  assign data_o  = mem[rd_ptr];
  assign count_o = count;

  // Storage: cleared on reset so the head reads 0 when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module stream_demux2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [WIDTH-1:0]       s_data_i,
  input  logic                   s_sel_i,
  output logic                   m0_valid_o,
  input  logic                   m0_ready_i,
  output logic [WIDTH-1:0]       m0_data_o,
  output logic                   m1_valid_o,
  input  logic                   m1_ready_i,
  output logic [WIDTH-1:0]       m1_data_o,
  output logic [$clog2(DEPTH):0] m0_count_o,
  output logic [$clog2(DEPTH):0] m1_count_o
);

  logic full0;
  logic full1;
  logic sel_full;
  logic push0;
  logic push1;

  // Steer the beat; ready depends only on sel and registered counts.
  always_comb begin
    sel_full = 1'b1;
    push0    = 1'b0;
    push1    = 1'b0;
    unique case (s_sel_i)
      1'b0: begin
        sel_full = full0;
        push0    = s_valid_i && !full0 && !rst_i;
      end
      1'b1: begin
        sel_full = full1;
        push1    = s_valid_i && !full1 && !rst_i;
      end
      default: begin
        sel_full = 1'b1;
      end
    endcase
  end

  assign s_ready_o = !rst_i && !sel_full;

  stream_demux2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push0),
    .data_i  (s_data_i),
    .full_o  (full0),
    .valid_o (m0_valid_o),
    .ready_i (m0_ready_i),
    .data_o  (m0_data_o),
    .count_o (m0_count_o)
  );

  stream_demux2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push1),
    .data_i  (s_data_i),
    .full_o  (full1),
    .valid_o (m1_valid_o),
    .ready_i (m1_ready_i),
    .data_o  (m1_data_o),
    .count_o (m1_count_o)
  );

endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: directed + random checks of stream_demux2.
// Reference model keeps each output FIFO as a plain queue.
module tb_stream_demux2;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_sel;
  logic          m0_valid;
  logic          m0_ready;
  logic [W-1:0]  m0_data;
  logic          m1_valid;
  logic          m1_ready;
  logic [W-1:0]  m1_data;
  logic [CW-1:0] m0_count;
  logic [CW-1:0] m1_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic acc_last;
  logic [W-1:0] mq0 [$];
  logic [W-1:0] mq1 [$];
  logic [W-1:0] rx0 [$];
  logic [W-1:0] rx1 [$];

  stream_demux2 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .s_sel_i    (s_sel),
    .m0_valid_o (m0_valid),
    .m0_ready_i (m0_ready),
    .m0_data_o  (m0_data),
    .m1_valid_o (m1_valid),
    .m1_ready_i (m1_ready),
    .m1_data_o  (m1_data),
    .m0_count_o (m0_count),
    .m1_count_o (m1_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    int n;
    n = s_sel ? mq1.size() : mq0.size();
    return n < D;
  endfunction

  task automatic check_all();
    chk("s_ready", W'(s_ready), W'(exp_ready()));
    chk("m0_valid", W'(m0_valid), W'(mq0.size() != 0));
    chk("m1_valid", W'(m1_valid), W'(mq1.size() != 0));
    chk("m0_count", W'(m0_count), W'(mq0.size()));
    chk("m1_count", W'(m1_count), W'(mq1.size()));
    if (mq0.size() != 0) chk("m0_data", m0_data, mq0[0]);
    if (mq1.size() != 0) chk("m1_data", m1_data, mq1[0]);
  endtask

  task automatic pre();
    #1;
    check_all();
  endtask

  task automatic post();
    logic acc, p0, p1;
    logic [W-1:0] d0, d1, tmp;
    acc = s_valid && exp_ready();
    p0  = (mq0.size() != 0) && m0_ready;
    p1  = (mq1.size() != 0) && m1_ready;
    d0  = m0_data;
    d1  = m1_data;
    @(posedge clk);
    if (p0) begin tmp = mq0.pop_front(); rx0.push_back(d0); end
    if (p1) begin tmp = mq1.pop_front(); rx1.push_back(d1); end
    if (acc) begin
      if (s_sel) mq1.push_back(s_data);
      else       mq0.push_back(s_data);
    end
    acc_last = acc;
    #1;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  // Upstream must hold data/sel while a beat is stalled.
  logic         stall_q;
  logic [W-1:0] hold_d;
  logic         hold_s;
  always @(posedge clk) begin
    if (!rst && stall_q && s_valid) begin
      n_cmp++;
      assert (s_data === hold_d && s_sel === hold_s) else begin
        n_bad++;
        $error("FAIL upstream_hold: observed %0h/%0b expected %0h/%0b",
               s_data, s_sel, hold_d, hold_s);
      end
    end
    stall_q <= !rst && s_valid && !s_ready;
    hold_d  <= s_data;
    hold_s  <= s_sel;
  end

  initial begin
    int nxt, budget, sent;
    logic pend;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sel = 1'b0;
    m0_ready = 1'b0; m1_ready = 1'b0; acc_last = 1'b0;

    // reset state
    #3;
    chk("rst_s_ready", W'(s_ready), W'(0));
    chk("rst_m0_valid", W'(m0_valid), W'(0));
    chk("rst_m1_valid", W'(m1_valid), W'(0));
    chk("rst_m0_count", W'(m0_count), W'(0));
    chk("rst_m1_count", W'(m1_count), W'(0));
    chk("rst_m0_data", m0_data, W'(0));
    chk("rst_m1_data", m1_data, W'(0));
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // idle: ready for either select, data outputs 0
    pre();
    chk("idle_ready_sel0", W'(s_ready), W'(1));
    s_sel = 1'b1; #1;
    chk("idle_ready_sel1", W'(s_ready), W'(1));
    chk("idle_m0_data", m0_data, W'(0));
    chk("idle_m1_data", m1_data, W'(0));
    s_sel = 1'b0;
    post();

    // single beat to output 0
    s_valid = 1'b1; s_data = 32'hA5A50001; s_sel = 1'b0; m0_ready = 1'b1;
    cycle();
    s_valid = 1'b0;
    pre();
    chk("t2_m0_valid", W'(m0_valid), W'(1));
    chk("t2_m0_data", m0_data, 32'hA5A50001);
    chk("t2_m1_valid", W'(m1_valid), W'(0));
    post();
    pre();
    chk("t2_m0_gone", W'(m0_valid), W'(0));
    post();

    // fill output 0, sel-1 beat passes, third sel-0 beat stalls
    rx0.delete(); rx1.delete();
    m0_ready = 1'b0; m1_ready = 1'b0;
    s_valid = 1'b1; s_sel = 1'b0; s_data = 32'd1; cycle();
    s_data = 32'd2; cycle();
    s_sel = 1'b1; s_data = 32'h77;
    pre();
    chk("t3_m0_count_full", W'(m0_count), W'(2));
    chk("t3_sel1_ready", W'(s_ready), W'(1));
    post();
    s_sel = 1'b0; s_data = 32'd3;
    pre();
    chk("t3_stall_ready", W'(s_ready), W'(0));
    chk("t3_m1_valid", W'(m1_valid), W'(1));
    chk("t3_m1_data", m1_data, 32'h77);
    post();

    // pop while full: push stays blocked this cycle, accepted next
    m0_ready = 1'b1;
    pre();
    chk("t4_full_pop_ready", W'(s_ready), W'(0));
    post();
    m0_ready = 1'b0;
    pre();
    chk("t4_count_after_pop", W'(m0_count), W'(1));
    chk("t4_ready_after_pop", W'(s_ready), W'(1));
    post();
    chk("t4_third_accepted", W'(acc_last), W'(1));
    s_valid = 1'b0; m0_ready = 1'b1; m1_ready = 1'b1;
    repeat (3) cycle();
    chk("t4_rx0_len", W'(rx0.size()), W'(3));
    for (int i = 0; i < 3; i++)
      if (i < rx0.size()) chk("t4_rx0_order", rx0[i], W'(i + 1));
    chk("t4_rx1_len", W'(rx1.size()), W'(1));
    if (rx1.size() != 0) chk("t4_rx1_data", rx1[0], 32'h77);

    // 10 beats alternating sel, random backpressure
    rx0.delete(); rx1.delete();
    nxt = 0; budget = 0; pend = 1'b0;
    while ((nxt < 10 || mq0.size() != 0 || mq1.size() != 0) && budget < 400) begin
      if (!pend && nxt < 10 && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1; s_data = W'(nxt); s_sel = nxt[0]; pend = 1'b1;
      end else if (!pend) begin
        s_valid = 1'b0;
      end
      m0_ready = 1'($urandom_range(0, 1));
      m1_ready = 1'($urandom_range(0, 1));
      cycle();
      if (pend && acc_last) begin pend = 1'b0; nxt++; s_valid = 1'b0; end
      budget++;
    end
    chk("t5_budget", W'(budget < 400), W'(1));
    chk("t5_rx0_len", W'(rx0.size()), W'(5));
    chk("t5_rx1_len", W'(rx1.size()), W'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < rx0.size()) chk("t5_rx0", rx0[i], W'(2 * i));
      if (i < rx1.size()) chk("t5_rx1", rx1[i], W'(2 * i + 1));
    end

    // random sweep: random sel/data/valid/ready
    sent = 0; budget = 0; pend = 1'b0;
    while (sent < 60 && budget < 2000) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        s_valid = 1'b1; s_data = $urandom; s_sel = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end else if (!pend) begin
        s_valid = 1'b0;
      end
      m0_ready = ($urandom_range(0, 3) != 0);
      m1_ready = ($urandom_range(0, 2) == 0);
      cycle();
      if (pend && acc_last) begin pend = 1'b0; sent++; s_valid = 1'b0; end
      budget++;
    end
    chk("t5r_budget", W'(budget < 2000), W'(1));
    s_valid = 1'b0; m0_ready = 1'b1; m1_ready = 1'b1;
    repeat (D + 1) cycle();

    // asynchronous reset with both FIFOs full
    m0_ready = 1'b0; m1_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = W'(32'h10 + i); s_sel = 1'(i % 2);
      cycle();
    end
    s_valid = 1'b0;
    pre();
    chk("t6_pre_m0_count", W'(m0_count), W'(2));
    chk("t6_pre_m1_count", W'(m1_count), W'(2));
    #1 rst = 1'b1;
    #1;
    chk("t6_m0_valid", W'(m0_valid), W'(0));
    chk("t6_m1_valid", W'(m1_valid), W'(0));
    chk("t6_m0_count", W'(m0_count), W'(0));
    chk("t6_m1_count", W'(m1_count), W'(0));
    chk("t6_s_ready", W'(s_ready), W'(0));
    chk("t6_m0_data", m0_data, W'(0));
    @(posedge clk); #2;
    chk("t6_hold_m1_valid", W'(m1_valid), W'(0));
    rst = 1'b0;
    mq0.delete(); mq1.delete(); rx0.delete(); rx1.delete();
    @(posedge clk); #1;
    m0_ready = 1'b1; m1_ready = 1'b1;
    s_valid = 1'b1; s_sel = 1'b0; s_data = 32'hB0; cycle();
    s_sel = 1'b1; s_data = 32'hB1; cycle();
    s_valid = 1'b0;
    repeat (3) cycle();
    chk("t6_rx0_len", W'(rx0.size()), W'(1));
    chk("t6_rx1_len", W'(rx1.size()), W'(1));
    if (rx0.size() != 0) chk("t6_rx0", rx0[0], 32'hB0);
    if (rx1.size() != 0) chk("t6_rx1", rx1[0], 32'hB1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
